// File: rtl/three_bit_comparator.sv
// Registered magnitude comparator, unsigned or two's complement.
// One-hot Greater/Less/Equal, one cycle after each valid sample.
module three_bit_comparator #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             Greater,
  output logic             Less,
  output logic             Equal
);

  logic sign_a;
  logic sign_b;
  logic eq_d;
  logic ult;
  logic lt_d;
  logic gt_d;

  logic vld_q;
  logic gt_q;
  logic lt_q;
  logic eq_q;

  assign sign_a = A[WIDTH-1];
  assign sign_b = B[WIDTH-1];
  assign eq_d   = (A == B);
  assign ult    = (A < B);

  // Mixed signs flip the unsigned order; same signs leave it intact.
  always_comb begin
    lt_d = ult;
    if (signed_mode && (sign_a != sign_b)) begin
      lt_d = sign_a;
    end
    gt_d = !lt_d && !eq_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        gt_q <= gt_d;
        lt_q <= lt_d;
        eq_q <= eq_d;
      end
    end
  end

  assign out_valid = vld_q;
  assign Greater   = gt_q;
  assign Less      = lt_q;
  assign Equal     = eq_q;

endmodule

// File: tb/tb_three_bit_comparator.sv
// Directed bench for three_bit_comparator.
// Observed word is {out_valid, Greater, Less, Equal}.
module tb_three_bit_comparator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       signed_mode;
  logic [2:0] A;
  logic [2:0] B;
  logic       out_valid;
  logic       Greater;
  logic       Less;
  logic       Equal;

  int n_tests;
  int n_fail;

  localparam logic [3:0] GT  = 4'b1100;
  localparam logic [3:0] LT  = 4'b1010;
  localparam logic [3:0] EQ  = 4'b1001;
  localparam logic [3:0] ZRO = 4'b0000;

  three_bit_comparator #(.WIDTH(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .out_valid   (out_valid),
    .Greater     (Greater),
    .Less        (Less),
    .Equal       (Equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] obs();
    return {out_valid, Greater, Less, Equal};
  endfunction

  task automatic check(
    input string      tag,
    input logic [3:0] got,
    input logic [3:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic       v,
    input logic [2:0] a,
    input logic [2:0] b,
    input logic       sm
  );
    @(negedge clk);
    in_valid    = v;
    A           = a;
    B           = b;
    signed_mode = sm;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] golden(
    input logic [2:0] a,
    input logic [2:0] b,
    input logic       sm
  );
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    if (sm && a[2]) ia = ia - 8;
    if (sm && b[2]) ib = ib - 8;
    if (ia > ib) return GT;
    if (ia < ib) return LT;
    return EQ;
  endfunction

  initial begin
    int big;
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    signed_mode = 1'b0;
    A           = '0;
    B           = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset", obs(), ZRO);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 3'd4, 3'd7, 1'b0);
    check("u 4,7", obs(), LT);
    drive(1'b1, 3'd1, 3'd3, 1'b0);
    check("u 1,3", obs(), LT);
    drive(1'b1, 3'd5, 3'd2, 1'b0);
    check("u 5,2", obs(), GT);
    drive(1'b1, 3'd6, 3'd5, 1'b0);
    check("u 6,5", obs(), GT);
    drive(1'b1, 3'd7, 3'd7, 1'b0);
    check("u 7,7", obs(), EQ);
    drive(1'b1, 3'd3, 3'd3, 1'b0);
    check("u 3,3", obs(), EQ);

    drive(1'b1, 3'b100, 3'b011, 1'b1);
    check("s -4,3", obs(), LT);
    drive(1'b1, 3'b100, 3'b011, 1'b0);
    check("u 4,3", obs(), GT);
    drive(1'b1, 3'b111, 3'b110, 1'b1);
    check("s -1,-2", obs(), GT);
    drive(1'b1, 3'b011, 3'b111, 1'b1);
    check("s 3,-1", obs(), GT);

    big = 111;
    drive(1'b1, big[2:0], 3'd6, 1'b0);
    check("trunc 111", obs(), GT);

    drive(1'b1, 3'd5, 3'd2, 1'b0);
    check("hold load", obs(), GT);
    drive(1'b0, 3'd0, 3'd7, 1'b0);
    check("hold 1", obs(), 4'b0100);
    drive(1'b0, 3'd3, 3'd3, 1'b1);
    check("hold 2", obs(), 4'b0100);
    drive(1'b0, 3'd1, 3'd6, 1'b0);
    check("hold 3", obs(), 4'b0100);

    drive(1'b1, 3'd2, 3'd5, 1'b0);
    check("pre rst", obs(), LT);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst", obs(), ZRO);
    @(negedge clk);
    rst_n = 1'b1;

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 64; i++) begin
        logic [2:0] a;
        logic [2:0] b;
        logic       sm;
        a  = 3'(i / 8);
        b  = 3'(i % 8);
        sm = (m == 1);
        drive(1'b1, a, b, sm);
        check($sformatf("ex m%0d %0d,%0d", m, a, b),
              obs(), golden(a, b, sm));
      end
    end

    @(negedge clk);
    in_valid    = 1'b1;
    A           = 3'd6;
    B           = 3'd5;
    signed_mode = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst now", obs(), ZRO);
    @(posedge clk);
    #1;
    check("mid rst edge", obs(), ZRO);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("post rst idle", obs(), ZRO);
    drive(1'b1, 3'd1, 3'd1, 1'b0);
    check("post rst load", obs(), EQ);
    drive(1'b0, 3'd0, 3'd0, 1'b0);
    check("post rst drop", obs(), 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
